// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: a six-state FSM that issues datapath
// controls from the current state and IR fields, with a countdown for mult/div.
module multi_cycle_ctrl #(
  parameter int MDU_CYCLES = 5,
  parameter int STATE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCEn,
  output logic               IREn,
  output logic [1:0]         PCsel,
  output logic               GRFEn,
  output logic [1:0]         A3sel,
  output logic [1:0]         WDsel,
  output logic [1:0]         EXTsel,
  output logic               Bsel,
  output logic [2:0]         ALUop,
  output logic               DMEn,
  output logic [1:0]         DMsel,
  output logic               MDUstart,
  output logic [1:0]         MDUop,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_MDU    = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                         OP_LW = 6'h23, OP_LB = 6'h20, OP_SW = 6'h2b,
                         OP_SB = 6'h28, OP_BEQ = 6'h04, OP_J = 6'h02,
                         OP_JAL = 6'h03;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_SRA = 6'h03, F_JR = 6'h08, F_JALR = 6'h09,
                         F_MULT = 6'h18, F_DIV = 6'h1a, F_MFHI = 6'h10,
                         F_MFLO = 6'h12;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic rtype;
  logic is_addu, is_subu, is_and, is_sra, is_jr, is_jalr;
  logic is_mult, is_div, is_mfhi, is_mflo;
  logic is_ori, is_lui, is_lw, is_lb, is_sw, is_sb, is_beq, is_j, is_jal;
  logic is_alu_r, is_load, is_store, is_mdu, is_mfx, is_known;

  assign rtype   = (opcode == OP_RTYPE);
  assign is_addu = rtype && (func == F_ADDU);
  assign is_subu = rtype && (func == F_SUBU);
  assign is_and  = rtype && (func == F_AND);
  assign is_sra  = rtype && (func == F_SRA);
  assign is_jr   = rtype && (func == F_JR);
  assign is_jalr = rtype && (func == F_JALR);
  assign is_mult = rtype && (func == F_MULT);
  assign is_div  = rtype && (func == F_DIV);
  assign is_mfhi = rtype && (func == F_MFHI);
  assign is_mflo = rtype && (func == F_MFLO);
  assign is_ori  = (opcode == OP_ORI);
  assign is_lui  = (opcode == OP_LUI);
  assign is_lw   = (opcode == OP_LW);
  assign is_lb   = (opcode == OP_LB);
  assign is_sw   = (opcode == OP_SW);
  assign is_sb   = (opcode == OP_SB);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_jal  = (opcode == OP_JAL);

  assign is_alu_r = is_addu | is_subu | is_and | is_sra;
  assign is_load  = is_lw | is_lb;
  assign is_store = is_sw | is_sb;
  assign is_mdu   = is_mult | is_div;
  assign is_mfx   = is_mfhi | is_mflo;
  assign is_known = is_alu_r | is_load | is_store | is_mdu | is_mfx | is_jr |
                    is_jalr | is_ori | is_lui | is_beq | is_j | is_jal;

  assign state = STATE_W'(state_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    PCEn     = 1'b0;
    IREn     = 1'b0;
    PCsel    = 2'b00;
    GRFEn    = 1'b0;
    A3sel    = 2'b00;
    WDsel    = 2'b00;
    EXTsel   = 2'b00;
    Bsel     = 1'b0;
    ALUop    = 3'b000;
    DMEn     = 1'b0;
    DMsel    = 2'b00;
    MDUstart = 1'b0;
    MDUop    = 2'b00;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IREn    = 1'b1;
        PCEn    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_j || is_jal) begin
          PCEn    = 1'b1;
          PCsel   = 2'b10;
          GRFEn   = is_jal;
          A3sel   = is_jal ? 2'b10 : 2'b00;
          WDsel   = is_jal ? 2'b10 : 2'b00;
          state_d = S_FETCH;
        end else if (is_jr || is_jalr) begin
          PCEn    = 1'b1;
          PCsel   = 2'b11;
          GRFEn   = is_jalr;
          WDsel   = is_jalr ? 2'b10 : 2'b00;
          state_d = S_FETCH;
        end else if (!is_known) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        state_d = S_FETCH;
        if (is_beq) begin
          ALUop = 3'b011;
          PCsel = 2'b01;
          PCEn  = zero;
        end else if (is_load || is_store) begin
          EXTsel  = 2'b01;
          Bsel    = 1'b1;
          state_d = S_MEM;
        end else if (is_ori || is_lui) begin
          EXTsel  = is_lui ? 2'b10 : 2'b00;
          Bsel    = 1'b1;
          ALUop   = is_ori ? 3'b010 : 3'b000;
          state_d = S_WB;
        end else if (is_alu_r) begin
          if (is_subu)     ALUop = 3'b001;
          else if (is_and) ALUop = 3'b100;
          else if (is_sra) ALUop = 3'b110;
          else             ALUop = 3'b000;
          state_d = S_WB;
        end else if (is_mdu) begin
          MDUstart = 1'b1;
          MDUop    = is_div ? 2'b01 : 2'b00;
          cnt_d    = 8'(MDU_CYCLES - 1);
          state_d  = S_MDU;
        end else if (is_mfx) begin
          MDUop   = is_mflo ? 2'b11 : 2'b10;
          state_d = S_WB;
        end
      end
      S_MEM: begin
        DMsel = (is_lb || is_sb) ? 2'b10 : 2'b00;
        DMEn  = is_store;
        if (mem_ready) state_d = is_store ? S_FETCH : S_WB;
      end
      // Counter was loaded with MDU_CYCLES-1, so hitting zero marks the last cycle here.
      S_MDU: begin
        MDUop = is_div ? 2'b01 : 2'b00;
        if (cnt_q == 8'd0) state_d = S_FETCH;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_WB: begin
        GRFEn   = 1'b1;
        A3sel   = (is_ori || is_lui || is_load) ? 2'b01 : 2'b00;
        WDsel   = is_load ? 2'b01 : (is_mfx ? 2'b11 : 2'b00);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: walks each instruction class cycle by
// cycle and compares state and control outputs against hand-derived values.
module tb_multi_cycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] func = 6'h21;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCEn, IREn, GRFEn, Bsel, DMEn, MDUstart, illegal;
  logic [1:0] PCsel, A3sel, WDsel, EXTsel, DMsel, MDUop;
  logic [2:0] ALUop;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  multi_cycle_ctrl #(.MDU_CYCLES(5), .STATE_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .PCEn(PCEn), .IREn(IREn), .PCsel(PCsel),
    .GRFEn(GRFEn), .A3sel(A3sel), .WDsel(WDsel), .EXTsel(EXTsel), .Bsel(Bsel),
    .ALUop(ALUop), .DMEn(DMEn), .DMsel(DMsel), .MDUstart(MDUstart),
    .MDUop(MDUop), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    func   = fn;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(6'h00, 6'h21);
    step();
    step();
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("[TB] FAIL reset_state got=%0d exp=0", state);
    end
    checks++;
    if ({IREn, PCEn, PCsel, GRFEn, DMEn, MDUstart, illegal} !== 8'b11_00_0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%b exp=11000000",
               {IREn, PCEn, PCsel, GRFEn, DMEn, MDUstart, illegal});
    end
    reset = 1'b1;
  endtask

  task automatic test_addu();
    logic [2:0] exp_s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    applyStimulus(6'h00, 6'h21);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i]) begin
        failures++; $display("[TB] FAIL addu_state cyc=%0d got=%0d exp=%0d", i, state, exp_s[i]);
      end
      checks++;
      if (GRFEn !== (exp_s[i] == 3'd4)) begin
        failures++; $display("[TB] FAIL addu_grfen cyc=%0d got=%b", i, GRFEn);
      end
      if (exp_s[i] == 3'd4) begin
        checks++;
        if ({A3sel, WDsel} !== 4'b0000) begin
          failures++; $display("[TB] FAIL addu_wb_sel got=%b exp=0000", {A3sel, WDsel});
        end
      end
    end
  endtask

  task automatic test_rtype_alu();
    logic [5:0] fns [3] = '{6'h23, 6'h24, 6'h03};
    logic [2:0] ops [3] = '{3'b001, 3'b100, 3'b110};
    for (int k = 0; k < 3; k++) begin
      applyStimulus(6'h00, fns[k]);
      step();
      step();
      checks++;
      if (state !== 3'd2 || ALUop !== ops[k] || Bsel !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rtype_aluop func=%h got state=%0d ALUop=%b Bsel=%b exp state=2 ALUop=%b Bsel=0",
                 fns[k], state, ALUop, Bsel, ops[k]);
      end
      step();
      step();
    end
  endtask

  task automatic test_beq();
    logic [2:0] exp_s [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    applyStimulus(6'h04, 6'h00);
    for (int z = 0; z < 2; z++) begin
      zero = (z == 1);
      for (int i = 0; i < 4; i++) begin
        if (i > 0) step();
        checks++;
        if (state !== exp_s[i]) begin
          failures++; $display("[TB] FAIL beq_state z=%0d cyc=%0d got=%0d exp=%0d", z, i, state, exp_s[i]);
        end
        if (i == 2) begin
          checks++;
          if (PCEn !== zero || PCsel !== 2'b01 || ALUop !== 3'b011) begin
            failures++;
            $display("[TB] FAIL beq_exe z=%0d got PCEn=%b PCsel=%b ALUop=%b exp PCEn=%b PCsel=01 ALUop=011",
                     z, PCEn, PCsel, ALUop, zero);
          end
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_lw_wait();
    logic [2:0] exp_s [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    applyStimulus(6'h23, 6'h00);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      mem_ready = (i >= 6);
      checks++;
      if (state !== exp_s[i]) begin
        failures++; $display("[TB] FAIL lw_state cyc=%0d got=%0d exp=%0d", i, state, exp_s[i]);
      end
      if (i == 2) begin
        checks++;
        if (EXTsel !== 2'b01 || Bsel !== 1'b1 || ALUop !== 3'b000) begin
          failures++; $display("[TB] FAIL lw_exe got EXTsel=%b Bsel=%b ALUop=%b", EXTsel, Bsel, ALUop);
        end
      end
      if (i == 7) begin
        checks++;
        if (GRFEn !== 1'b1 || A3sel !== 2'b01 || WDsel !== 2'b01) begin
          failures++;
          $display("[TB] FAIL lw_wb got GRFEn=%b A3sel=%b WDsel=%b exp 1 01 01", GRFEn, A3sel, WDsel);
        end
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_sb();
    logic [2:0] exp_s [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    applyStimulus(6'h28, 6'h00);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (state !== exp_s[i] || GRFEn !== 1'b0) begin
        failures++;
        $display("[TB] FAIL sb_state cyc=%0d got state=%0d GRFEn=%b exp state=%0d GRFEn=0",
                 i, state, GRFEn, exp_s[i]);
      end
      if (i == 3) begin
        checks++;
        if (DMEn !== 1'b1 || DMsel !== 2'b10) begin
          failures++; $display("[TB] FAIL sb_mem got DMEn=%b DMsel=%b exp 1 10", DMEn, DMsel);
        end
      end
    end
  endtask

  task automatic test_ori();
    applyStimulus(6'h0d, 6'h00);
    step();
    step();
    checks++;
    if (state !== 3'd2 || EXTsel !== 2'b00 || Bsel !== 1'b1 || ALUop !== 3'b010) begin
      failures++;
      $display("[TB] FAIL ori_exe got state=%0d EXTsel=%b Bsel=%b ALUop=%b exp 2 00 1 010",
               state, EXTsel, Bsel, ALUop);
    end
    step();
    checks++;
    if (state !== 3'd4 || GRFEn !== 1'b1 || A3sel !== 2'b01 || WDsel !== 2'b00) begin
      failures++;
      $display("[TB] FAIL ori_wb got state=%0d GRFEn=%b A3sel=%b WDsel=%b exp 4 1 01 00",
               state, GRFEn, A3sel, WDsel);
    end
    step();
  endtask

  task automatic test_jal();
    applyStimulus(6'h03, 6'h00);
    step();
    checks++;
    if (state !== 3'd1 || PCEn !== 1'b1 || PCsel !== 2'b10 || GRFEn !== 1'b1 ||
        A3sel !== 2'b10 || WDsel !== 2'b10) begin
      failures++;
      $display("[TB] FAIL jal_decode got state=%0d PCEn=%b PCsel=%b GRFEn=%b A3sel=%b WDsel=%b",
               state, PCEn, PCsel, GRFEn, A3sel, WDsel);
    end
    step();
    checks++;
    if (state !== 3'd0) begin
      failures++; $display("[TB] FAIL jal_return got=%0d exp=0", state);
    end
  endtask

  task automatic test_mult();
    logic [2:0] exp_s [9] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0};
    int starts = 0;
    applyStimulus(6'h00, 6'h18);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      if (MDUstart === 1'b1) starts++;
      checks++;
      if (state !== exp_s[i]) begin
        failures++; $display("[TB] FAIL mult_state cyc=%0d got=%0d exp=%0d", i, state, exp_s[i]);
      end
      if (exp_s[i] == 3'd5) begin
        checks++;
        if (MDUop !== 2'b00 || MDUstart !== 1'b0) begin
          failures++; $display("[TB] FAIL mult_mdu cyc=%0d got MDUop=%b MDUstart=%b", i, MDUop, MDUstart);
        end
      end
    end
    checks++;
    if (starts != 1) begin
      failures++; $display("[TB] FAIL mult_start_count got=%0d exp=1", starts);
    end
  endtask

  task automatic test_back_to_back();
    applyStimulus(6'h00, 6'h1a);
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (state !== 3'd5 || MDUop !== 2'b01) begin
      failures++; $display("[TB] FAIL div_mdu3 got state=%0d MDUop=%b exp 5 01", state, MDUop);
    end
    reset = 1'b0;
    step();
    checks++;
    if (state !== 3'd0 || MDUstart !== 1'b0 || GRFEn !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mdu_abort got state=%0d MDUstart=%b GRFEn=%b exp 0 0 0", state, MDUstart, GRFEn);
    end
    reset = 1'b1;
    applyStimulus(6'h3f, 6'h00);
    step();
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1 ||
        {PCEn, IREn, GRFEn, DMEn, MDUstart} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL illegal_decode got state=%0d illegal=%b enables=%b exp 1 1 00000",
               state, illegal, {PCEn, IREn, GRFEn, DMEn, MDUstart});
    end
    step();
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0) begin
      failures++; $display("[TB] FAIL illegal_after got state=%0d illegal=%b exp 0 0", state, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_rtype_alu();
    test_beq();
    test_lw_wait();
    test_sb();
    test_ori();
    test_jal();
    test_mult();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter MDU_CYCLES, default 5, giving the number of cycles the controller stays in S_MDU per mult/div (legal range 1..255).
REQ-002 SHALL have parameter STATE_W, default 3, giving the width of the state output.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have ports:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-low reset
  opcode  in  6  IR[31:26], valid from S_DECODE onward
  func  in  6  IR[5:0]
  zero  in  1  ALU equality flag, sampled in S_EXE
  mem_ready  in  1  data-memory handshake, sampled in S_MEM
  PCEn  out  1  PC write enable
  IREn  out  1  IR write enable
  PCsel  out  2  00 PC+4, 01 branch, 10 jump, 11 register
  GRFEn  out  1  register-file write enable
  A3sel  out  2  00 rd, 01 rt, 10 $31
  WDsel  out  2  00 ALU, 01 DM, 10 link, 11 HI/LO
  EXTsel  out  2  00 zero, 01 sign, 10 upper
  Bsel  out  1  0 rt, 1 immediate
  ALUop  out  3  000 add, 001 sub, 010 or, 011 eq, 100 and, 110 sra
  DMEn  out  1  data-memory write strobe
  DMsel  out  2  00 word, 10 byte
  MDUstart  out  1  one-cycle start pulse to the mult/div unit
  MDUop  out  2  00 mult, 01 div, 10 mfhi, 11 mflo
  illegal  out  1  one-cycle pulse on an undecoded instruction
  state  out  STATE_W  current state encoding

Function
REQ-005 SHALL decode addu, subu, and, sra, jr, jalr, mult, div, mfhi, mflo (opcode 0, by func), and ori, lui, lw, lb, sw, sb, beq, j, jal (by opcode).
REQ-006 SHALL implement states S_FETCH=0, S_DECODE=1, S_EXE=2, S_MEM=3, S_WB=4, S_MDU=5; encodings 6 and 7 SHALL go to S_FETCH on the next cycle.
REQ-007 SHALL generate all outputs combinationally from state plus opcode/func; outputs not listed for a state SHALL be 0.
REQ-008 S_FETCH: IREn=1, PCEn=1, PCsel=00; next state S_DECODE.
REQ-009 S_DECODE, j/jal: PCEn=1, PCsel=10; jal also GRFEn=1, A3sel=10, WDsel=10; next S_FETCH.
REQ-010 S_DECODE, jr/jalr: PCEn=1, PCsel=11; jalr also GRFEn=1, A3sel=00, WDsel=10; next S_FETCH.
REQ-011 S_DECODE, undecoded instruction: illegal=1; next S_FETCH, with no write enables asserted.
REQ-012 S_DECODE, all other instructions: next S_EXE.
REQ-013 S_EXE, beq: ALUop=011, PCsel=01, PCEn=zero; next S_FETCH.
REQ-014 S_EXE, loads/stores: EXTsel=01, Bsel=1, ALUop=000; next S_MEM.
REQ-015 S_EXE, ori/lui: EXTsel=00/10 respectively, Bsel=1, ALUop=010/000; next S_WB.
REQ-016 S_EXE, R-type ALU ops: Bsel=0; ALUop per REQ-004; next S_WB.
REQ-017 S_EXE, mult/div: MDUstart=1, MDUop=00/01; load the cycle counter with MDU_CYCLES-1; next S_MDU.
REQ-018 S_EXE, mfhi/mflo: MDUop=10/11; next S_WB.
REQ-019 S_MDU: MDUop held; the counter decrements each cycle; at counter 0 the next state is S_FETCH, so the block spends exactly MDU_CYCLES cycles in S_MDU; MDUstart SHALL NOT re-assert.
REQ-020 S_MEM: DMsel=10 for lb/sb, else 00; for stores DMEn=1 every cycle in the state.
REQ-021 S_MEM: stay while mem_ready=0; on mem_ready=1, stores go to S_FETCH and loads go to S_WB; mem_ready is ignored in all other states.
REQ-022 S_WB: GRFEn=1.
REQ-023 S_WB: A3sel=01 for ori/lui/lw/lb, else 00.
REQ-024 S_WB: WDsel=01 for loads, 11 for mfhi/mflo, else 00; next S_FETCH.
REQ-025 Each instruction SHALL cost the following cycles with mem_ready tied high: jumps 2, beq 3, ALU/mfhi/mflo 4, store 4, load 5, mult/div 3+MDU_CYCLES.

Reset
REQ-026 While reset=0 at a rising edge: state becomes S_FETCH, counter becomes 0, and outputs take S_FETCH values on the following cycle; no MDUstart or GRFEn pulse from the aborted instruction.
REQ-027 Reset SHALL override every state, including S_MEM waiting and S_MDU counting; the first fetch is the cycle after reset is released.

Verification
REQ-028 Release reset, addu: states 0,1,2,4,0; GRFEn=1 only in S_WB, with A3sel=00 and WDsel=00.
REQ-029 beq, zero=0 then zero=1: PCEn=0 / PCEn=1 in S_EXE with PCsel=01; 3 cycles each.
REQ-030 lw, mem_ready low 3 cycles then high: 3 extra S_MEM cycles, then S_WB with GRFEn=1, A3sel=01, WDsel=01; total 8 cycles.
REQ-031 sb with MDU_CYCLES=5: DMEn=1 and DMsel=10 in S_MEM, no GRFEn.
REQ-032 mult with MDU_CYCLES=5: MDUstart high exactly 1 cycle, S_MDU lasts 5 cycles, 8 cycles total.
REQ-033 Reset asserted during the 3rd S_MDU cycle -> state 0 next cycle, no further S_MDU; opcode 6'b111111 -> illegal pulses once in S_DECODE with no enables.
